// File: rtl/mdu_pkg.sv
// Shared encodings for the HI/LO multiply/divide sequencer: op codes,
// FSM state type, divider iteration count and a magnitude helper.
package mdu_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam int unsigned DIV_ITERS = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } mdu_state_e;

  function automatic logic [31:0] magnitude(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? 32'(-v) : v;
  endfunction

endpackage

// File: rtl/div_iter_core.sv
// Unsigned restoring divider: one quotient bit per step, DIV_ITERS steps
// after a load. done flags the step that produces the final bit.
module div_iter_core
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] q,
  output logic [31:0] r,
  output logic        done
);

  localparam int unsigned ITER_W = $clog2(DIV_ITERS);

  logic [31:0]       rem_q;
  logic [31:0]       quo_q;
  logic [31:0]       dsr_q;
  logic [ITER_W-1:0] cnt_q;
  logic [32:0]       trial;
  logic [32:0]       diff;
  logic              fits;

  // trial < 2*divisor, so the sign bit of diff is a clean compare result
  always_comb begin
    trial = {rem_q, quo_q[31]};
    diff  = trial - {1'b0, dsr_q};
    fits  = ~diff[32];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dsr_q <= '0;
      cnt_q <= '0;
    end else if (load) begin
      rem_q <= '0;
      quo_q <= dividend;
      dsr_q <= divisor;
      cnt_q <= '0;
    end else if (step) begin
      rem_q <= fits ? diff[31:0] : trial[31:0];
      quo_q <= {quo_q[30:0], fits};
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign q    = quo_q;
  assign r    = rem_q;
  assign done = step && (cnt_q == ITER_W'(DIV_ITERS - 1));

endmodule

// File: rtl/muldiv_sequencer.sv
// MULT/MULTU/DIV/DIVU sequencer feeding HI/LO: stalls EX while an op runs
// and issues a single-cycle 64-bit HI/LO write on completion.
//
//   state | meaning
//   IDLE  | waiting for start; accepts and latches operands
//   MUL   | registered multiplier pipeline filling
//   DIV   | divider iterating, one quotient bit per cycle
//   DONE  | result presented, hi_lo_we for this cycle only
module muldiv_sequencer
  import mdu_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        stall,
  output logic [63:0] hi_lo_data,
  output logic        hi_lo_we,
  output logic        div_by_zero
);

  localparam int unsigned CNT_MAX = (MUL_CYCLES > DIV_ITERS) ? MUL_CYCLES : DIV_ITERS;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       op_q;
  logic [31:0]      a_q, b_q;
  logic             dz_q;
  logic [63:0]      hold_q;

  logic             accept;
  logic             div_load, div_step, div_done;
  logic [31:0]      div_q, div_r;
  logic [31:0]      div_q_fix, div_r_fix;
  logic             neg_q, neg_r;
  logic [63:0]      ext_a, ext_b, mul_prod, mul_result;
  logic [63:0]      result;

  assign accept   = (state_q == ST_IDLE) && start && !flush;
  assign div_load = accept && op[1];
  assign div_step = (state_q == ST_DIV) && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stall       = 1'b0;
    hi_lo_we    = 1'b0;
    div_by_zero = 1'b0;
    if (flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            stall = 1'b1;
            cnt_d = '0;
            if (!op[1])            state_d = ST_MUL;
            else if (src_b == '0)  state_d = ST_DONE;
            else                   state_d = ST_DIV;
          end
        end
        ST_MUL: begin
          stall = 1'b1;
          if (cnt_q == CNT_W'(MUL_CYCLES - 1)) begin
            state_d = ST_DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_DIV: begin
          stall = 1'b1;
          if (div_done) begin
            state_d = ST_DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_DONE: begin
          // start here still belongs to the completing instruction
          hi_lo_we    = 1'b1;
          div_by_zero = dz_q;
          state_d     = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q <= OP_MULT;
      a_q  <= '0;
      b_q  <= '0;
      dz_q <= 1'b0;
    end else if (accept) begin
      op_q <= op;
      a_q  <= src_a;
      b_q  <= src_b;
      dz_q <= op[1] && (src_b == '0);
    end
  end

  div_iter_core u_div (
    .clk      (clk),
    .rst      (rst),
    .load     (div_load),
    .step     (div_step),
    .dividend (magnitude(src_a, op == OP_DIV)),
    .divisor  (magnitude(src_b, op == OP_DIV)),
    .q        (div_q),
    .r        (div_r),
    .done     (div_done)
  );

  always_comb begin
    ext_a    = (op_q == OP_MULT) ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
    ext_b    = (op_q == OP_MULT) ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
    mul_prod = ext_a * ext_b;
  end

  generate
    if (MUL_CYCLES > 1) begin : g_mul_pipe
      logic [63:0] pipe [MUL_CYCLES-1];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < int'(MUL_CYCLES) - 1; i++) pipe[i] <= '0;
        end else begin
          pipe[0] <= mul_prod;
          for (int i = 1; i < int'(MUL_CYCLES) - 1; i++) pipe[i] <= pipe[i-1];
        end
      end
      assign mul_result = pipe[MUL_CYCLES-2];
    end else begin : g_mul_comb
      assign mul_result = mul_prod;
    end
  endgenerate

  // MIN_INT / -1 wraps naturally: magnitude 2^31 negated is 0x80000000
  always_comb begin
    neg_q     = (op_q == OP_DIV) && (a_q[31] ^ b_q[31]);
    neg_r     = (op_q == OP_DIV) && a_q[31];
    div_q_fix = neg_q ? 32'(-div_q) : div_q;
    div_r_fix = neg_r ? 32'(-div_r) : div_r;
    if (dz_q)          result = {a_q, 32'hFFFF_FFFF};
    else if (op_q[1])  result = {div_r_fix, div_q_fix};
    else               result = mul_result;
  end

  always_ff @(posedge clk) begin
    if (rst)                     hold_q <= '0;
    else if (state_q == ST_DONE) hold_q <= result;
  end

  assign hi_lo_data = (state_q == ST_DONE) ? result : hold_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed and randomized bench for muldiv_sequencer against an arithmetic
// reference model of MULT/MULTU/DIV/DIVU HI/LO results and cycle latencies.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        stall;
  logic [63:0] hi_lo_data;
  logic        hi_lo_we;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;

  muldiv_sequencer #(.MUL_CYCLES(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op          (op),
    .src_a       (src_a),
    .src_b       (src_b),
    .flush       (flush),
    .stall       (stall),
    .hi_lo_data  (hi_lo_data),
    .hi_lo_we    (hi_lo_we),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                        input logic [31:0] b, output logic dz);
    longint sa, sb, sq, sr;
    logic [63:0] p;
    dz = 1'b0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'b00: begin p = 64'(sa * sb); return p; end
      2'b01: begin p = 64'(a) * 64'(b); return p; end
      default: begin
        if (b == 32'd0) begin
          dz = 1'b1;
          return {a, 32'hFFFF_FFFF};
        end
        if (o == 2'b10) begin
          sq = sa / sb;
          sr = sa % sb;
          return {sr[31:0], sq[31:0]};
        end
        return {a % b, a / b};
      end
    endcase
  endfunction

  function automatic int latency(input logic [1:0] o, input logic [31:0] b);
    if (!o[1]) return 3;
    if (b == 32'd0) return 1;
    return 33;
  endfunction

  // Start in the next cycle; operand inputs are scrambled while stalled to
  // confirm only the values latched at acceptance are used.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp_data,
                        input logic exp_dz, input int exp_lat);
    logic seen;
    tick();
    flush = 1'b0;
    start = 1'b1; op = o; src_a = a; src_b = b;
    #1;
    check({tag, ".stall0"}, stall, 1'b1);
    seen = 1'b0;
    for (int n = 1; n <= 60 && !seen; n++) begin
      tick();
      op = 2'($urandom); src_a = $urandom; src_b = $urandom;
      #1;
      if (hi_lo_we) begin
        seen = 1'b1;
        check({tag, ".latency"}, 64'(n), 64'(exp_lat));
        check({tag, ".data"}, hi_lo_data, exp_data);
        check({tag, ".dz"}, div_by_zero, exp_dz);
        check({tag, ".stall_done"}, stall, 1'b0);
      end else begin
        check({tag, ".stall_busy"}, stall, 1'b1);
      end
    end
    if (!seen) check({tag, ".timeout"}, 64'd0, 64'd1);
    start = 1'b0;
  endtask

  task automatic run_model(input string tag, input logic [1:0] o, input logic [31:0] a,
                           input logic [31:0] b);
    logic dz;
    logic [63:0] e;
    e = model(o, a, b, dz);
    run_op(tag, o, a, b, e, dz, latency(o, b));
  endtask

  initial begin
    logic any_we;
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
    tick(); tick();
    check("rst.stall", stall, 1'b0);
    check("rst.we", hi_lo_we, 1'b0);
    check("rst.dz", div_by_zero, 1'b0);
    check("rst.data", hi_lo_data, 64'd0);
    rst = 1'b0;

    run_op("mult_neg3x5", 2'b00, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, 1'b0, 3);
    run_op("multu_max_x2", 2'b01, 32'hFFFF_FFFF, 32'd2, 64'h0000_0001_FFFF_FFFE, 1'b0, 3);
    run_op("div_7_neg2", 2'b10, 32'd7, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 1'b0, 33);
    run_op("divu_100_7", 2'b11, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0, 33);
    run_op("divu_by_zero", 2'b11, 32'h1234, 32'd0, 64'h0000_1234_FFFF_FFFF, 1'b1, 1);
    run_op("div_minint_m1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b0, 33);
    run_op("div_neg_by_zero", 2'b10, 32'hFFFF_FF00, 32'd0, 64'hFFFF_FF00_FFFF_FFFF, 1'b1, 1);

    // start held only through DONE: the cycle after must not write again
    tick();
    check("after_done.we", hi_lo_we, 1'b0);

    // flush at cycle 10 of a DIV, then a MULT starting at cycle 11
    tick();
    start = 1'b1; op = 2'b10; src_a = 32'd1000; src_b = 32'd3;
    any_we = 1'b0;
    for (int n = 1; n <= 9; n++) begin
      tick();
      if (hi_lo_we) any_we = 1'b1;
    end
    tick();
    flush = 1'b1;
    #1;
    if (hi_lo_we) any_we = 1'b1;
    check("flush.stall", stall, 1'b0);
    check("flush.no_we", any_we, 1'b0);
    run_op("mult_after_flush", 2'b00, 32'd6, 32'hFFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFD6, 1'b0, 3);

    // flush and start in the same IDLE cycle: nothing latched
    tick();
    start = 1'b1; flush = 1'b1; op = 2'b01; src_a = 32'd3; src_b = 32'd4;
    #1;
    check("flush_start.stall", stall, 1'b0);
    tick();
    start = 1'b0; flush = 1'b0;
    #1;
    check("flush_start.stall_next", stall, 1'b0);
    any_we = 1'b0;
    for (int n = 0; n < 6; n++) begin
      tick();
      if (hi_lo_we) any_we = 1'b1;
    end
    check("flush_start.no_we", any_we, 1'b0);

    // flush in DONE suppresses the write
    tick();
    start = 1'b1; op = 2'b11; src_a = 32'h55; src_b = 32'd0;
    tick();
    flush = 1'b1;
    #1;
    check("flush_done.we", hi_lo_we, 1'b0);
    check("flush_done.dz", div_by_zero, 1'b0);
    tick();
    flush = 1'b0; start = 1'b0;
    #1;
    check("flush_done.we_next", hi_lo_we, 1'b0);

    // reset at cycle 5 of a DIV
    tick();
    start = 1'b1; op = 2'b10; src_a = 32'hFFFF_0000; src_b = 32'd9;
    for (int n = 1; n <= 4; n++) tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    #1;
    check("midrst.stall", stall, 1'b0);
    check("midrst.we", hi_lo_we, 1'b0);
    check("midrst.dz", div_by_zero, 1'b0);
    check("midrst.data", hi_lo_data, 64'd0);
    any_we = 1'b0;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (hi_lo_we) any_we = 1'b1;
    end
    check("midrst.no_we", any_we, 1'b0);

    // randomized back-to-back ops against the reference model
    for (int k = 0; k < 30; k++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = 32'd1;
        3: ra = 32'h8000_0000;
        default: ;
      endcase
      run_model("rand", ro, ra, rb);
    end

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
